io_output_hs: RTL and testbench

IO_OUTPUT_HS -- requirements
Module: io_output_hs

---
 rtl/io_output_hs_pkg.sv | 18 +
 rtl/io_output_port.sv | 48 ++++
 rtl/io_output_hs.sv | 75 +++++++
 tb/tb_io_output_hs.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_output_hs_pkg.sv
// Shared I/O address map: port/status selectors and status-word bit layout,
// common to the output and input decoders.
package io_output_hs_pkg;
  localparam int          IO_MAX_PORTS      = 4;
  localparam logic [5:0]  IO_BASE_SEL       = 6'b100000;
  localparam logic [5:0]  IO_STAT_SEL       = 6'b101111;
  localparam int          IO_STAT_VALID_LSB = 0;
  localparam int          IO_STAT_OVR_LSB   = 8;

  function automatic logic [31:0] io_status_word(input logic [3:0] ovr,
                                                 input logic [3:0] vld);
    logic [31:0] w;
    w = '0;
    w[IO_STAT_OVR_LSB +: 4]   = ovr;
    w[IO_STAT_VALID_LSB +: 4] = vld;
    return w;
  endfunction
endpackage

// File: rtl/io_output_port.sv
// One output port: data register, pending-valid flag and sticky overrun flag.
module io_output_port (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic        ack_i,
  input  logic        ovr_clr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        ovr_o
);
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic        ovr_set;

  // An ack landing on the same edge as a store means the old word was taken.
  assign ovr_set = wr_i & valid_q & ~ack_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (ack_i && valid_q) begin
      valid_d = 1'b0;
    end
    ovr_d = ovr_set | (ovr_q & ~ovr_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ovr_o   = ovr_q;
endmodule

// File: rtl/io_output_hs.sv
// Memory-mapped output ports with valid/ack handshake, sticky overrun and a
// status register; decode and readback mux live here.
module io_output_hs
  import io_output_hs_pkg::*;
#(
  parameter int         NPORT    = 3,
  parameter logic [5:0] BASE_SEL = IO_BASE_SEL,
  parameter logic [5:0] STAT_SEL = IO_STAT_SEL
) (
  input  logic             io_clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      datain,
  input  logic             write_io_enable,
  output logic [31:0]      out_port0,
  output logic [31:0]      out_port1,
  output logic [31:0]      out_port2,
  output logic [31:0]      out_port3,
  output logic [NPORT-1:0] out_valid,
  input  logic [NPORT-1:0] out_ack,
  output logic [31:0]      io_read_data
);
  logic [5:0]                  sel;
  logic                        stat_wr;
  logic [NPORT-1:0]            port_wr;
  logic [NPORT-1:0]            ovr;
  logic [NPORT-1:0][31:0]      port_data;
  logic [IO_MAX_PORTS-1:0][31:0] pdata4;
  logic [3:0]                  vld4, ovr4;
  logic                        unused_addr;

  assign sel         = addr[7:2];
  assign stat_wr     = write_io_enable && (sel == STAT_SEL);
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  for (genvar k = 0; k < NPORT; k++) begin : g_port
    assign port_wr[k] = write_io_enable && (sel == 6'(BASE_SEL + k));

    io_output_port u_port (
      .clk_i     (io_clk),
      .rst_i     (reset),
      .wr_i      (port_wr[k]),
      .ack_i     (out_ack[k]),
      .ovr_clr_i (stat_wr & datain[IO_STAT_OVR_LSB + k]),
      .data_i    (datain),
      .data_o    (port_data[k]),
      .valid_o   (out_valid[k]),
      .ovr_o     (ovr[k])
    );
  end

  // Zero-pad to the full 4-port map so unused ports and status bits read 0.
  always_comb begin
    pdata4 = '0;
    vld4   = '0;
    ovr4   = '0;
    for (int k = 0; k < NPORT; k++) begin
      pdata4[k] = port_data[k];
      vld4[k]   = out_valid[k];
      ovr4[k]   = ovr[k];
    end
  end

  assign out_port0 = pdata4[0];
  assign out_port1 = pdata4[1];
  assign out_port2 = pdata4[2];
  assign out_port3 = pdata4[3];

  always_comb begin
    io_read_data = '0;
    if (sel == STAT_SEL) io_read_data = io_status_word(ovr4, vld4);
    for (int k = 0; k < NPORT; k++)
      if (sel == 6'(BASE_SEL + k)) io_read_data = port_data[k];
  end
endmodule

// File: tb/tb_io_output_hs.sv
// Randomized and directed bench for io_output_hs against a behavioural model.
module tb_io_output_hs;
  localparam int NP = 3;

  logic          io_clk = 1'b0;
  logic          reset;
  logic [31:0]   addr, datain;
  logic          write_io_enable;
  logic [31:0]   out_port0, out_port1, out_port2, out_port3;
  logic [NP-1:0] out_valid, out_ack;
  logic [31:0]   io_read_data;

  int n_chk = 0;
  int n_fail = 0;

  // Model state
  logic [31:0] m_data [NP];
  logic        m_vld  [NP];
  logic        m_ovr  [NP];

  io_output_hs #(.NPORT(NP)) dut (
    .io_clk(io_clk), .reset(reset), .addr(addr), .datain(datain),
    .write_io_enable(write_io_enable),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
    .out_port3(out_port3), .out_valid(out_valid), .out_ack(out_ack),
    .io_read_data(io_read_data)
  );

  always #5 io_clk = ~io_clk;

  function automatic void model_reset();
    for (int k = 0; k < NP; k++) begin
      m_data[k] = '0; m_vld[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int s;
    logic [31:0] r;
    s = int'(a[7:2]);
    r = '0;
    if (s >= 32 && s < 32 + NP) r = m_data[s-32];
    else if (s == 47)
      for (int k = 0; k < NP; k++) begin
        if (m_vld[k]) r = r + (32'd1 << k);
        if (m_ovr[k]) r = r + (32'd1 << (8 + k));
      end
    return r;
  endfunction

  function automatic logic [NP-1:0] exp_vld();
    logic [NP-1:0] v;
    for (int k = 0; k < NP; k++) v[k] = m_vld[k];
    return v;
  endfunction

  // Drive one bus cycle, advance the model by one edge, land #1 after the edge.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [NP-1:0] ack);
    int s;
    bit set_now [NP];
    write_io_enable = we; addr = a; datain = d; out_ack = ack;
    @(posedge io_clk);
    s = int'(a[7:2]);
    for (int k = 0; k < NP; k++) begin
      set_now[k] = 1'b0;
      if (we && s == 32 + k) begin
        if (m_vld[k] && !ack[k]) begin m_ovr[k] = 1'b1; set_now[k] = 1'b1; end
        m_data[k] = d;
        m_vld[k]  = 1'b1;
      end else if (ack[k]) begin
        m_vld[k] = 1'b0;
      end
      if (we && s == 47 && d[8+k] && !set_now[k]) m_ovr[k] = 1'b0;
    end
    #1;
    write_io_enable = 1'b0; out_ack = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; write_io_enable = 0; addr = 0; datain = 0; out_ack = 0;
    model_reset();
    repeat (2) @(posedge io_clk);
    #1;
    n_chk++;
    if ({out_port0, out_port1, out_port2, out_port3, out_valid} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h %h %h %h v=%b want all 0",
                         out_port0, out_port1, out_port2, out_port3, out_valid);
    end
    addr = 32'hBC; #1;
    n_chk++;
    if (io_read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_status got %h want 0", io_read_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_store_basic();
    cyc(1, 32'h80, 32'h1234_5678, '0);
    n_chk++;
    if (out_port0 !== 32'h1234_5678 || out_valid !== 3'b001) begin
      n_fail++; $display("FAIL store_p0 got %h v=%b want 12345678 v=001", out_port0, out_valid);
    end
    addr = 32'hBC; #1;
    n_chk++;
    if (io_read_data !== 32'h0000_0001) begin
      n_fail++; $display("FAIL store_status got %h want 00000001", io_read_data);
    end
  endtask

  task automatic test_ack();
    cyc(0, 32'h0, 32'h0, 3'b001);
    n_chk++;
    if (out_port0 !== 32'h1234_5678 || out_valid !== 3'b000) begin
      n_fail++; $display("FAIL ack_p0 got %h v=%b want 12345678 v=000", out_port0, out_valid);
    end
    cyc(0, 32'h0, 32'h0, 3'b001);   // ack with nothing pending is ignored
    n_chk++;
    if (out_valid !== 3'b000) begin
      n_fail++; $display("FAIL ack_idle got v=%b want 000", out_valid);
    end
  endtask

  task automatic test_overrun();
    cyc(1, 32'h84, 32'hAAAA_0001, '0);
    cyc(1, 32'h84, 32'hBBBB_0002, '0);
    addr = 32'hBC; #1;
    n_chk++;
    if (out_port1 !== 32'hBBBB_0002 || io_read_data !== 32'h0000_0202) begin
      n_fail++; $display("FAIL overrun got p1=%h st=%h want bbbb0002 00000202", out_port1, io_read_data);
    end
    cyc(1, 32'hBC, 32'h200, '0);
    addr = 32'hBC; #1;
    n_chk++;
    if (io_read_data !== 32'h0000_0002) begin
      n_fail++; $display("FAIL ovr_clear got %h want 00000002", io_read_data);
    end
  endtask

  task automatic test_store_ack_same();
    cyc(1, 32'h88, 32'h0000_C0DE, '0);
    cyc(1, 32'h88, 32'hFACE_0000, 3'b100);
    addr = 32'hBC; #1;
    n_chk++;
    if (out_port2 !== 32'hFACE_0000 || out_valid[2] !== 1'b1 || io_read_data[10] !== 1'b0) begin
      n_fail++; $display("FAIL store_ack got p2=%h v=%b st=%h want face0000 v2=1 ovr2=0",
                         out_port2, out_valid, io_read_data);
    end
    n_chk++;
    if (io_read_data !== 32'h0000_0006) begin
      n_fail++; $display("FAIL store_ack_status got %h want 00000006", io_read_data);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] p0, p1, p2; logic [NP-1:0] v;
    p0 = out_port0; p1 = out_port1; p2 = out_port2; v = out_valid;
    cyc(1, 32'h90, 32'hDEAD_BEEF, '0);
    n_chk++;
    if (io_read_data !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_read got %h want 0", io_read_data);
    end
    addr = 32'hBC; #1;
    n_chk++;
    if (out_port0 !== p0 || out_port1 !== p1 || out_port2 !== p2 || out_valid !== v ||
        io_read_data !== 32'h0000_0006) begin
      n_fail++; $display("FAIL unmapped_state got %h %h %h v=%b st=%h want unchanged st=00000006",
                         out_port0, out_port1, out_port2, out_valid, io_read_data);
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 32'h80, 32'h11, '0);
    cyc(1, 32'h84, 32'h22, '0);   // also overruns port 1 (still pending)
    n_chk++;
    if (out_valid !== 3'b111) begin
      n_fail++; $display("FAIL pre_reset got v=%b want 111", out_valid);
    end
    addr = 32'hBC;
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({out_port0, out_port1, out_port2, out_valid} !== '0 || io_read_data !== 32'h0) begin
      n_fail++; $display("FAIL async_reset got %h %h %h v=%b st=%h want all 0",
                         out_port0, out_port1, out_port2, out_valid, io_read_data);
    end
    model_reset();
    #1 reset = 1'b0;
    cyc(1, 32'h88, 32'h33, '0);
    n_chk++;
    if (out_port2 !== 32'h33 || out_valid !== 3'b100) begin
      n_fail++; $display("FAIL post_reset got p2=%h v=%b want 33 v=100", out_port2, out_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [NP-1:0] ack;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = 32'h80 + 32'(4 * $urandom_range(0, 3));
        3:       a = 32'hBC;
        default: a = $urandom;
      endcase
      ack = NP'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), a,
          ($urandom_range(0, 1) != 0) ? $urandom : ($urandom & 32'h0000_0700), ack);
      addr = a; #1;
      n_chk++;
      if (out_port0 !== m_data[0] || out_port1 !== m_data[1] || out_port2 !== m_data[2] ||
          out_port3 !== 32'h0 || out_valid !== exp_vld() || io_read_data !== exp_read(a)) begin
        n_fail++;
        $display("FAIL random[%0d] got %h %h %h %h v=%b rd=%h want %h %h %h 0 v=%b rd=%h",
                 i, out_port0, out_port1, out_port2, out_port3, out_valid, io_read_data,
                 m_data[0], m_data[1], m_data[2], exp_vld(), exp_read(a));
      end
      addr = 32'hBC; #1;
      n_chk++;
      if (io_read_data !== exp_read(32'hBC)) begin
        n_fail++; $display("FAIL random_status[%0d] got %h want %h", i, io_read_data, exp_read(32'hBC));
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_basic();
    test_ack();
    test_overrun();
    test_store_ack_same();
    test_unmapped();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
